// File: rtl/card_cnt_seg7.sv
// -----------------------------------------------------------------------------
// card_cnt_seg7
//
// Shows two 7-bit card counters as decimal on a 4-digit, multiplexed
// seven-segment display.
//   - Left pair of digits (DIGIT[3:2]) shows deck_card_cnt.
//   - Right pair of digits (DIGIT[1:0]) shows oppo_card_cnt.
// When either input differs from the last converted snapshot, a sequential
// double-dabble engine converts both counters to BCD. The engine uses one
// IDLE cycle, seven SHIFT cycles and one COMMIT cycle. The display BCD
// registers change only in COMMIT, so the display never shows a partial
// result. Values of 100..127 show as two dashes.
//
// Ports
//   clk            in   1  system clock, the only clock
//   rst            in   1  synchronous, active-high reset
//   oppo_card_cnt  in   7  opponent hand count, shown on DIGIT[1:0]
//   deck_card_cnt  in   7  deck count, shown on DIGIT[3:2]
//   DISPLAY        out  7  segments, active-low, DISPLAY[0]=a .. DISPLAY[6]=g
//   DIGIT          out  4  anode enables, active-low, DIGIT[3]=leftmost
//   busy           out  1  high while a BCD conversion is in progress
//
// Parameter
//   REFRESH_BITS   width of the scan counter. Its top two bits select the
//                  digit, so each digit is lit for 2^(REFRESH_BITS-2) cycles.
// -----------------------------------------------------------------------------
module card_cnt_seg7 #(
    parameter int REFRESH_BITS = 17
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] oppo_card_cnt,
    input  logic [6:0] deck_card_cnt,
    output logic [6:0] DISPLAY,
    output logic [3:0] DIGIT,
    output logic       busy
);

    // Lane 0 is the opponent count (right digits).
    // Lane 1 is the deck count (left digits).
    localparam int NUM_LANES  = 2;
    localparam int NUM_DIGITS = 4;
    localparam int BIN_W      = 7;
    // Scratch layout: {tens[3:0], ones[3:0], bin[6:0]}.
    localparam int SCR_W      = 8 + BIN_W;

    localparam logic [6:0] SEG_DASH  = 7'b0111111;  // only g lit
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [2:0] LAST_ITER = 3'd6;        // 7 shift iterations: 0..6
    localparam logic [REFRESH_BITS-1:0] REFRESH_ONE = 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // Helper functions
    // -------------------------------------------------------------------------

    // One double-dabble iteration: first add 3 to any BCD nibble >= 5, then
    // shift the whole {bcd, bin} register left by one bit. The hundreds
    // digit falls off the top for 100..127. That is harmless, because those
    // values are shown as dashes.
    function automatic logic [SCR_W-1:0] dabble_step(input logic [SCR_W-1:0] s);
        logic [SCR_W-1:0] a;
        a = s;
        if (a[14:11] >= 4'd5) begin
            a[14:11] = a[14:11] + 4'd3;
        end
        if (a[10:7] >= 4'd5) begin
            a[10:7] = a[10:7] + 4'd3;
        end
        return {a[SCR_W-2:0], 1'b0};
    endfunction

    // Active-low segment decode. The bit order is gfedcba.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_BLANK;   // unreachable: BCD digits are 0..9
        endcase
        return s;
    endfunction

    // -------------------------------------------------------------------------
    // Control FSM
    // -------------------------------------------------------------------------
    state_t                 state_reg, state_next;
    logic [2:0]             iter_reg, iter_next;
    logic                   load_en;
    logic                   shift_en;
    logic                   commit_en;
    logic [NUM_LANES-1:0]   lane_changed;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            iter_reg  <= 3'd0;
        end else begin
            state_reg <= state_next;
            iter_reg  <= iter_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        iter_next  = iter_reg;
        load_en    = 1'b0;
        shift_en   = 1'b0;
        commit_en  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                // Both lanes reload together, even if only one count
                // changed. The snapshots then always form a consistent pair.
                if (|lane_changed) begin
                    load_en    = 1'b1;
                    iter_next  = 3'd0;
                    state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                shift_en = 1'b1;
                if (iter_reg == LAST_ITER) begin
                    state_next = ST_COMMIT;
                end else begin
                    iter_next = iter_reg + 3'd1;
                end
            end
            ST_COMMIT: begin
                commit_en  = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // busy is a decode of the state register, so it is glitch-free. It
    // covers the seven SHIFT cycles and the COMMIT cycle.
    assign busy = (state_reg != ST_IDLE);

    // -------------------------------------------------------------------------
    // Conversion lanes
    // -------------------------------------------------------------------------
    logic [BIN_W-1:0] lane_in   [NUM_LANES];
    logic [3:0]       lane_tens [NUM_LANES];
    logic [3:0]       lane_ones [NUM_LANES];
    logic             lane_over [NUM_LANES];

    assign lane_in[0] = oppo_card_cnt;
    assign lane_in[1] = deck_card_cnt;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            logic [BIN_W-1:0] snap_reg;
            logic [SCR_W-1:0] scratch_reg;
            logic [SCR_W-1:0] scratch_next;
            logic [3:0]       tens_reg;
            logic [3:0]       ones_reg;
            logic             over_reg;

            assign scratch_next = dabble_step(scratch_reg);

            always_ff @(posedge clk) begin
                if (rst) begin
                    snap_reg    <= '0;
                    scratch_reg <= '0;
                    tens_reg    <= 4'd0;
                    ones_reg    <= 4'd0;
                    over_reg    <= 1'b0;
                end else begin
                    if (load_en) begin
                        snap_reg    <= lane_in[gi];
                        scratch_reg <= {8'd0, lane_in[gi]};
                    end else if (shift_en) begin
                        scratch_reg <= scratch_next;
                    end
                    // The snapshot is stable for the whole conversion, so
                    // the over-range flag comes from it, not from the BCD.
                    if (commit_en) begin
                        tens_reg <= scratch_reg[14:11];
                        ones_reg <= scratch_reg[10:7];
                        over_reg <= (snap_reg >= 7'd100);
                    end
                end
            end

            assign lane_changed[gi] = (lane_in[gi] != snap_reg);
            assign lane_tens[gi]    = tens_reg;
            assign lane_ones[gi]    = ones_reg;
            assign lane_over[gi]    = over_reg;
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Digit patterns
    // Digit position p maps to lane p/2. Odd positions hold the tens digit.
    // -------------------------------------------------------------------------
    logic [6:0] digit_seg [NUM_DIGITS];

    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            localparam int LANE    = gi / 2;
            localparam bit IS_TENS = ((gi % 2) == 1);
            assign digit_seg[gi] = lane_over[LANE] ? SEG_DASH :
                                   seg7(IS_TENS ? lane_tens[LANE] : lane_ones[LANE]);
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Scan multiplexer
    // The outputs are registered, so they lag the scan index by one cycle.
    // -------------------------------------------------------------------------
    logic [REFRESH_BITS-1:0] refresh_reg;
    logic [1:0]              scan_idx;
    logic [6:0]              display_reg, display_next;
    logic [3:0]              digit_reg, digit_next;

    assign scan_idx = refresh_reg[REFRESH_BITS-1 -: 2];

    always_comb begin
        display_next = digit_seg[scan_idx];
        digit_next   = ~(4'b0001 << scan_idx);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            refresh_reg <= '0;
            display_reg <= SEG_BLANK;
            digit_reg   <= 4'b1111;
        end else begin
            refresh_reg <= refresh_reg + REFRESH_ONE;
            display_reg <= display_next;
            digit_reg   <= digit_next;
        end
    end

    assign DISPLAY = display_reg;
    assign DIGIT   = digit_reg;

endmodule
